// File: rtl/ysyx_22050019_icache_pkg.sv
// Shared types and AXI constants for the direct-mapped instruction cache.
package ysyx_22050019_icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_AR,
        S_MISS_R,
        S_RESP
    } state_e;

    localparam int unsigned LINE_W = 128;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned ADDR_W = 32;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_8B     = 3'd3;
    localparam logic [7:0] BURST_LEN   = 8'd1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_22050019_icache_array.sv
// Tag/data storage with a flash-clearable valid vector; one comb read port, one write port.
module ysyx_22050019_icache_array
    import ysyx_22050019_icache_pkg::*;
#(
    parameter int unsigned LINES = 64,
    parameter int unsigned IW    = 6,
    parameter int unsigned TW    = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [IW-1:0]     rd_idx,
    output logic              rd_valid_c,
    output logic [TW-1:0]     rd_tag_c,
    output logic [LINE_W-1:0] rd_data_c,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [TW-1:0]     wr_tag,
    input  logic [LINE_W-1:0] wr_data
);

    logic [LINES-1:0]  valid_q;
    logic [TW-1:0]     tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];

    // Reset here is active-high even though the port keeps the rst_n name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid_c = valid_q[rd_idx];
    assign rd_tag_c   = tag_mem[rd_idx];
    assign rd_data_c  = data_mem[rd_idx];

endmodule

// File: rtl/ysyx_22050019_icache.sv
// Direct-mapped read-only I-cache: 128-bit line upstream, 2-beat 64-bit AXI refill downstream.
module ysyx_22050019_icache
    import ysyx_22050019_icache_pkg::*;
#(
    parameter int unsigned LINES     = 64,
    parameter logic [31:0] RESET_VAL = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ar_valid_i,
    output logic              ar_ready_o,
    input  logic [31:0]       ar_addr_i,
    output logic              r_valid_o,
    input  logic              r_ready_i,
    output logic [LINE_W-1:0] r_data_o,
    output logic [1:0]        r_resp_o,
    input  logic              fence_i_i,
    output logic              mem_ar_valid_o,
    input  logic              mem_ar_ready_i,
    output logic [31:0]       mem_ar_addr_o,
    output logic [7:0]        mem_ar_len_o,
    output logic [2:0]        mem_ar_size_o,
    output logic [1:0]        mem_ar_burst_o,
    input  logic              mem_r_valid_i,
    output logic              mem_r_ready_o,
    input  logic [BEAT_W-1:0] mem_r_data_i,
    input  logic [1:0]        mem_r_resp_i,
    input  logic              mem_r_last_i
);

    localparam int unsigned IW = $clog2(LINES);
    localparam int unsigned TW = 28 - IW;

    state_e            state_q;
    logic [27:0]       line_q;
    logic [BEAT_W-1:0] lo_q;
    logic [LINE_W-1:0] data_q;
    logic [1:0]        resp_q;
    logic              beat_q;
    logic              err_q;
    logic              fence_pend_q;

    logic              rd_valid_c;
    logic [TW-1:0]     rd_tag_c;
    logic [LINE_W-1:0] rd_data_c;
    logic              in_idle_c;
    logic              fence_now_c;
    logic              flush_c;
    logic              hit_c;
    logic              beat_err_c;
    logic              wr_en_c;
    logic              unused_addr_lo;

    assign unused_addr_lo = ^ar_addr_i[3:0];

    // A fence arriving in the same IDLE cycle as a request wins over it.
    assign in_idle_c   = (state_q == S_IDLE);
    assign fence_now_c = fence_pend_q | fence_i_i;
    assign flush_c     = in_idle_c & fence_now_c & ~rst_n;
    assign hit_c       = rd_valid_c & (rd_tag_c == line_q[27:IW]);
    assign beat_err_c  = (mem_r_resp_i != RESP_OKAY) | (mem_r_last_i != beat_q);
    assign wr_en_c     = ~rst_n & (state_q == S_MISS_R) & mem_r_valid_i & beat_q
                       & ~err_q & ~beat_err_c;

    ysyx_22050019_icache_array #(
        .LINES (LINES),
        .IW    (IW),
        .TW    (TW)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_c),
        .rd_idx     (line_q[IW-1:0]),
        .rd_valid_c (rd_valid_c),
        .rd_tag_c   (rd_tag_c),
        .rd_data_c  (rd_data_c),
        .wr_en      (wr_en_c),
        .wr_idx     (line_q[IW-1:0]),
        .wr_tag     (line_q[27:IW]),
        .wr_data    ({mem_r_data_i, lo_q})
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            line_q       <= RESET_VAL[31:4];
            lo_q         <= '0;
            data_q       <= '0;
            resp_q       <= RESP_OKAY;
            beat_q       <= 1'b0;
            err_q        <= 1'b0;
            fence_pend_q <= 1'b0;
        end else begin
            // Any pending fence is applied (flash clear) whenever the FSM sits in IDLE.
            if (in_idle_c) begin
                fence_pend_q <= 1'b0;
            end else if (fence_i_i) begin
                fence_pend_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (ar_valid_i && !fence_now_c) begin
                        line_q  <= ar_addr_i[31:4];
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit_c) begin
                        data_q  <= rd_data_c;
                        resp_q  <= RESP_OKAY;
                        state_q <= S_RESP;
                    end else begin
                        state_q <= S_MISS_AR;
                    end
                end
                S_MISS_AR: begin
                    if (mem_ar_ready_i) begin
                        beat_q  <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= S_MISS_R;
                    end
                end
                S_MISS_R: begin
                    if (mem_r_valid_i) begin
                        if (!beat_q) begin
                            lo_q   <= mem_r_data_i;
                            err_q  <= beat_err_c;
                            beat_q <= 1'b1;
                        end else begin
                            data_q  <= {mem_r_data_i, lo_q};
                            resp_q  <= (err_q | beat_err_c) ? RESP_SLVERR : RESP_OKAY;
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (r_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Handshake outputs decode the state register and are forced low while reset is held.
    assign ar_ready_o     = ~rst_n & in_idle_c & ~fence_now_c;
    assign r_valid_o      = ~rst_n & (state_q == S_RESP);
    assign r_data_o       = rst_n ? '0 : data_q;
    assign r_resp_o       = rst_n ? RESP_OKAY : resp_q;
    assign mem_ar_valid_o = ~rst_n & (state_q == S_MISS_AR);
    assign mem_ar_addr_o  = mem_ar_valid_o ? {line_q, 4'b0000} : '0;
    assign mem_r_ready_o  = ~rst_n & (state_q == S_MISS_R);
    assign mem_ar_len_o   = BURST_LEN;
    assign mem_ar_size_o  = SIZE_8B;
    assign mem_ar_burst_o = BURST_INCR;

endmodule

// File: tb/tb_ysyx_22050019_icache.sv
// Scoreboard bench for the I-cache: line-level cache model, AXI memory responder, response monitor.
module tb_ysyx_22050019_icache;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ar_valid, ar_ready;
    logic [31:0]  ar_addr;
    logic         r_valid, r_ready;
    logic [127:0] r_data;
    logic [1:0]   r_resp;
    logic         fence_i;
    logic         mem_ar_valid, mem_ar_ready;
    logic [31:0]  mem_ar_addr;
    logic [7:0]   mem_ar_len;
    logic [2:0]   mem_ar_size;
    logic [1:0]   mem_ar_burst;
    logic         mem_r_valid, mem_r_ready;
    logic [63:0]  mem_r_data;
    logic [1:0]   mem_r_resp;
    logic         mem_r_last;

    always #5 clk = ~clk;

    ysyx_22050019_icache #(.LINES(64), .RESET_VAL(32'h8000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ar_valid_i     (ar_valid),
        .ar_ready_o     (ar_ready),
        .ar_addr_i      (ar_addr),
        .r_valid_o      (r_valid),
        .r_ready_i      (r_ready),
        .r_data_o       (r_data),
        .r_resp_o       (r_resp),
        .fence_i_i      (fence_i),
        .mem_ar_valid_o (mem_ar_valid),
        .mem_ar_ready_i (mem_ar_ready),
        .mem_ar_addr_o  (mem_ar_addr),
        .mem_ar_len_o   (mem_ar_len),
        .mem_ar_size_o  (mem_ar_size),
        .mem_ar_burst_o (mem_ar_burst),
        .mem_r_valid_i  (mem_r_valid),
        .mem_r_ready_o  (mem_r_ready),
        .mem_r_data_i   (mem_r_data),
        .mem_r_resp_i   (mem_r_resp),
        .mem_r_last_i   (mem_r_last)
    );

    typedef struct {
        logic [127:0] data;
        logic [1:0]   resp;
        bit           chk_data;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mv    [64];
    logic [31:0] mline [64];
    int          burst_cnt = 0;
    logic [31:0] burst_addr = '0;
    int          err_mode = 0;
    bit          stall_beat1 = 0;
    int          mb_beat = 0;
    bit          mb_active = 0;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Backing memory: every 16-byte line has fixed, beat-distinct content.
    function automatic logic [63:0] mem_beat(input logic [31:0] line, input int b);
        if (line == 32'h8000_0000)
            return (b == 0) ? 64'h1111_1111_1111_1111 : 64'h2222_2222_2222_2222;
        return {line ^ 32'h5a5a_0000, ~line} + 64'(b) * 64'h0123_4567_89ab_cdef;
    endfunction

    task automatic model_clear();
        foreach (mv[i]) mv[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AXI memory responder: random ready/valid gaps, optional error injection per burst.
    initial begin
        bit prev_arv, prev_rr;
        int cur_err;
        prev_arv = 0; prev_rr = 0; cur_err = 0;
        mem_ar_ready = 0; mem_r_valid = 0; mem_r_data = '0; mem_r_resp = 2'b00; mem_r_last = 0;
        forever begin
            tick();
            if (rst_n) begin
                mem_ar_ready = 0; mem_r_valid = 0; mb_active = 0;
                prev_arv = 0; prev_rr = 0;
            end else begin
                if (prev_arv && mem_ar_ready) begin
                    burst_cnt++;
                    mb_active = 1; mb_beat = 0;
                    cur_err = err_mode;
                    err_mode = 0;
                end
                if (prev_rr && mem_r_valid) begin
                    mb_beat++;
                    if (mb_beat == 2) mb_active = 0;
                end
                mem_ar_ready = !mb_active && mem_ar_valid && ($urandom_range(0, 2) != 0);
                if (mem_ar_ready) begin
                    burst_addr = mem_ar_addr;
                    check("ar_len", 128'(mem_ar_len), 128'(8'd1));
                    check("ar_size", 128'(mem_ar_size), 128'(3'd3));
                    check("ar_burst", 128'(mem_ar_burst), 128'(2'b01));
                end
                mem_r_valid = mb_active && !(stall_beat1 && mb_beat == 1) && ($urandom_range(0, 3) != 0);
                mem_r_data  = mem_r_valid ? mem_beat(burst_addr, mb_beat) : 64'hdead_beef_dead_beef;
                mem_r_resp  = (cur_err == 1 && mb_beat == 1) ? 2'b10 : 2'b00;
                mem_r_last  = (mb_beat == 1) ^ (cur_err == 2 && mb_beat == 0) ^ (cur_err == 3 && mb_beat == 1);
                prev_arv = mem_ar_valid;
                prev_rr  = mem_r_ready;
            end
        end
    end

    // Monitor: pops the scoreboard on each upstream r handshake, checks stability under backpressure.
    initial begin
        exp_t         e;
        logic [127:0] held;
        bit           holding;
        holding = 0; held = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                holding = 0;
            end else if (r_valid) begin
                if (holding) check("hold_data", r_data, held);
                check("ar_ready_in_resp", 128'(ar_ready), 128'(1'b0));
                if (r_ready) begin
                    if (sb.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_resp: got resp=%0h data=%0h with empty scoreboard", r_resp, r_data);
                    end else begin
                        e = sb.pop_front();
                        check("r_resp", 128'(r_resp), 128'(e.resp));
                        if (e.chk_data) check("r_data", r_data, e.data);
                    end
                    holding = 0;
                end else begin
                    held = r_data;
                    holding = 1;
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input int err, input bit fence_mid,
                           input bit fence_with_ar, input int hold);
        logic [31:0] line;
        int          idx, b0, cyc, n;
        bit          miss, rdy, fenced;
        exp_t        e;
        line = {a[31:4], 4'b0000};
        idx  = int'(a[9:4]);
        if (fence_with_ar) model_clear();
        miss       = !(mv[idx] && mline[idx] == line);
        e.resp     = (miss && err != 0) ? 2'b10 : 2'b00;
        e.chk_data = (e.resp == 2'b00);
        e.data     = {mem_beat(line, 1), mem_beat(line, 0)};
        if (miss && err == 0) begin
            mv[idx] = 1'b1;
            mline[idx] = line;
        end
        err_mode = miss ? err : 0;
        sb.push_back(e);
        b0 = burst_cnt;

        ar_valid = 1; ar_addr = a;
        if (fence_with_ar) fence_i = 1;
        cyc = 0; rdy = 0;
        do begin
            #1;
            rdy = ar_ready;
            if (fence_with_ar && cyc == 0) check("fence_blocks_ar", 128'(rdy), 128'(1'b0));
            @(posedge clk); #1;
            fence_i = 0;
            cyc++;
        end while (!rdy && cyc < 50);
        ar_valid = 0;
        if (!rdy) begin
            n_tests++; n_fail++;
            $display("FAIL ar_timeout: ar_ready never high for addr %0h", a);
            void'(sb.pop_back());
            return;
        end
        if (fence_with_ar) check("fence_ar_delay", 128'(cyc), 128'(2));

        n = 0; fenced = 0;
        while (!r_valid && n < 400) begin
            if (fence_mid && !fenced && mem_r_ready) begin
                fence_i = 1; fenced = 1;
                model_clear();
            end
            tick();
            fence_i = 0;
            n++;
        end
        if (!r_valid) begin
            n_tests++; n_fail++;
            $display("FAIL rvalid_timeout: no r_valid for addr %0h", a);
            return;
        end
        if (!miss) check("hit_latency", 128'(n), 128'(1));

        repeat (hold) tick();
        r_ready = 1;
        tick();
        r_ready = 0;
        check("burst_count", 128'(burst_cnt - b0), 128'(miss ? 1 : 0));
        if (miss) check("burst_addr", 128'(burst_addr), 128'(line));
        if (fence_mid) begin
            check("fence_ar_ready_low", 128'(ar_ready), 128'(1'b0));
            tick();
            check("ar_ready_after_fence", 128'(ar_ready), 128'(1'b1));
        end else begin
            check("ar_ready_b2b", 128'(ar_ready), 128'(1'b1));
        end
    endtask

    task automatic pulse_fence();
        fence_i = 1;
        #1;
        check("idle_fence_ar_ready", 128'(ar_ready), 128'(1'b0));
        tick();
        fence_i = 0;
        model_clear();
        #1;
        check("idle_fence_release", 128'(ar_ready), 128'(1'b1));
    endtask

    initial begin
        logic [31:0] a;
        int          ev, cyc;
        bit          rdy;
        rst_n = 1; ar_valid = 0; ar_addr = '0; r_ready = 0; fence_i = 0;
        model_clear();
        repeat (3) tick();
        check("rst_ar_ready", 128'(ar_ready), 128'(1'b0));
        check("rst_r_valid", 128'(r_valid), 128'(1'b0));
        check("rst_r_data", r_data, 128'(0));
        check("rst_mem_ar_valid", 128'(mem_ar_valid), 128'(1'b0));
        check("rst_mem_r_ready", 128'(mem_r_ready), 128'(1'b0));
        check("rst_len", 128'(mem_ar_len), 128'(8'd1));
        check("rst_size", 128'(mem_ar_size), 128'(3'd3));
        check("rst_burst", 128'(mem_ar_burst), 128'(2'b01));
        rst_n = 0;
        tick();
        check("ar_ready_after_rst", 128'(ar_ready), 128'(1'b1));

        do_read(32'h8000_0004, 0, 0, 0, 0);
        do_read(32'h8000_0004, 0, 0, 0, 0);
        do_read(32'h8000_0000, 0, 0, 0, 0);
        do_read(32'h8000_0400, 0, 0, 0, 0);
        do_read(32'h8000_0000, 0, 0, 0, 0);
        do_read(32'h8000_0020, 1, 0, 0, 0);
        do_read(32'h8000_0020, 0, 0, 0, 0);
        do_read(32'h8000_0030, 2, 0, 0, 0);
        do_read(32'h8000_0034, 3, 0, 0, 0);
        do_read(32'h8000_0038, 0, 0, 0, 0);
        do_read(32'h8000_0050, 0, 1, 0, 0);
        do_read(32'h8000_0050, 0, 0, 0, 0);
        do_read(32'h8000_005c, 0, 0, 0, 5);
        do_read(32'h8000_0050, 0, 0, 1, 0);

        // Reset while the refill is between beat 0 and beat 1.
        stall_beat1 = 1;
        err_mode = 0;
        ar_valid = 1; ar_addr = 32'h9000_0050;
        cyc = 0; rdy = 0;
        do begin #1; rdy = ar_ready; tick(); cyc++; end while (!rdy && cyc < 50);
        ar_valid = 0;
        cyc = 0;
        while (!(mb_active && mb_beat == 1) && cyc < 200) begin tick(); cyc++; end
        check("beat0_reached", 128'(mb_beat), 128'(1));
        rst_n = 1;
        #1;
        check("midrst_mem_r_ready", 128'(mem_r_ready), 128'(1'b0));
        check("midrst_mem_ar_valid", 128'(mem_ar_valid), 128'(1'b0));
        check("midrst_r_valid", 128'(r_valid), 128'(1'b0));
        check("midrst_ar_ready", 128'(ar_ready), 128'(1'b0));
        repeat (3) tick();
        rst_n = 0; stall_beat1 = 0;
        model_clear();
        tick();
        check("ar_ready_after_midrst", 128'(ar_ready), 128'(1'b1));
        do_read(32'h9000_0050, 0, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) pulse_fence();
            a = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 4)
                | (32'($urandom_range(0, 3)) << 10) | 32'($urandom_range(0, 15));
            ev = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_read(a, ev, 0, 0, int'($urandom_range(0, 3)));
        end

        repeat (3) tick();
        check("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_icache.md
# ysyx_22050019_icache

Direct-mapped, read-only instruction cache between the fetch buffer (upstream, 128-bit line requests) and the memory-side AXI master (downstream, 64-bit data bus). Each upstream read returns one aligned 16-byte line. A miss refills the line with a 2-beat INCR burst. A `fence_i_i` pulse invalidates every line.

## Interface
Parameters:
- `LINES`, 64: number of lines, power of two. Index width `IW = log2(LINES)`. Tag width `TW = 28 - IW`.
- `RESET_VAL`, 32'h80000000: documentation only; no reset-time prefetch.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset. **Synchronous, active-high** despite the name.
- `ar_valid_i` in 1: upstream line request valid.
- `ar_ready_o` out 1: request accepted.
- `ar_addr_i` in 32: request address; bits [3:0] ignored.
- `r_valid_o` out 1: line data valid.
- `r_ready_i` in 1: upstream accepts data.
- `r_data_o` out 128: line; bits [31:0] are at byte offset 0.
- `r_resp_o` out 2: 00 OKAY, 10 SLVERR.
- `fence_i_i` in 1: invalidate-all request, one-cycle pulse.
- `mem_ar_valid_o` out 1, `mem_ar_ready_i` in 1: refill address handshake.
- `mem_ar_addr_o` out 32: refill address.
- `mem_ar_len_o` out 8: constant 1.
- `mem_ar_size_o` out 3: constant 3.
- `mem_ar_burst_o` out 2: constant 01.
- `mem_r_valid_i` in 1, `mem_r_ready_o` out 1: refill data handshake.
- `mem_r_data_i` in 64: refill data beat.
- `mem_r_resp_i` in 2: refill beat response.
- `mem_r_last_i` in 1: last beat of burst.

## Operation
- Address split: `tag = a[31:4+IW]`, `idx = a[3+IW:4]`.
- FSM states: IDLE, LOOKUP, MISS_AR, MISS_R, RESP.
- IDLE:
  - `ar_ready_o = ~fence_pend`.
  - On the ar handshake, register the address and go to LOOKUP.
- LOOKUP:
  - Hit = `valid[idx] & tag_arr[idx]==tag`.
  - Hit: latch `data_arr[idx]`, resp 00, go to RESP.
  - Miss: go to MISS_AR.
- MISS_AR:
  - `mem_ar_valid_o=1`, `mem_ar_addr_o={addr[31:4],4'b0}`.
  - On handshake, clear the beat counter and go to MISS_R.
- MISS_R:
  - `mem_r_ready_o=1`.
  - Beat 0 fills [63:0]; beat 1 fills [127:64].
  - Error is set if any beat resp ≠ 00, or `mem_r_last_i` disagrees with the beat count (last must be 0 on beat 0 and 1 on beat 1).
  - On beat 1:
    - No error: write data, tag, valid=1 to the array.
    - Error: no array write; `r_resp_o=10`.
    - Either way, go to RESP.
- RESP:
  - `r_valid_o=1`, `r_data_o`/`r_resp_o` held stable.
  - On `r_ready_i`, go to IDLE.
  - A started transaction is never abandoned; upstream discards unwanted data itself.
- Fence:
  - `fence_i_i` sets `fence_pend` in any state.
  - When the FSM is in IDLE with `fence_pend` set, all valid bits clear in that cycle, `fence_pend` clears, and `ar_ready_o=0` for that cycle.
  - A line refilled before the pending fence applies is therefore invalidated.

## Timing
- Reset:
  - State IDLE; all valid bits 0; `fence_pend=0`.
  - During reset all outputs are 0, including `ar_ready_o`.
  - Constant outputs (`mem_ar_len_o`, `mem_ar_size_o`, `mem_ar_burst_o`) keep their values during reset.
  - `ar_ready_o=1` from the first cycle after reset.
- Reset asserted mid-refill:
  - Returns the FSM to IDLE and drops `mem_*` valid/ready immediately.
  - The downstream master is also in reset on the same `rst_n`.
- Hit latency: ar handshake at edge N, `r_valid_o` high from edge N+2.
- Miss latency: `mem_ar_valid_o` high from edge N+2; `r_valid_o` high the cycle after the edge accepting beat 1.
- Back-to-back: the next `ar_ready_o` is high the cycle after the r handshake. There is no request overlap.
- Simultaneous fence and ar in IDLE:
  - Fence wins; ar is not accepted.
  - The request is accepted one cycle later and misses.
- `mem_r_valid_i` is ignored outside MISS_R.
- Data array: the read path in LOOKUP is combinational from the registered index. Array writes occur on the clock edge.

## Structure
- Package `ysyx_22050019_icache_pkg`:
  - State enum.
  - AXI constants: `BURST_INCR=2'b01`, `SIZE_8B=3'd3`, `RESP_OKAY=2'b00`, `RESP_SLVERR=2'b10`.
  - Line width 128, beat width 64.
- Sub-module `ysyx_22050019_icache_array`:
  - Tag and data arrays.
  - Valid vector with synchronous reset and one-cycle flash clear.
  - One read port, one write port.

## Test plan
- Cold miss, then hit:
  - Read 0x80000004 with memory returning beats 0x1111…/0x2222… → one burst at 0x80000000, len 1, r_data = {0x2222…,0x1111…}, resp 00.
  - Repeat the read → hit, `r_valid_o` 2 cycles after ar, no `mem_ar_valid_o`.
- Conflict eviction (LINES=64):
  - Read 0x80000000, then 0x80000400 (same idx, new tag) → second read misses.
  - Read 0x80000000 again → misses again.
- Error beat:
  - Beat 1 resp=10 → r_resp 10.
  - Re-read the same line → misses (no fill occurred).
- Fence during refill:
  - Pulse `fence_i_i` in MISS_R → the current response completes normally.
  - `ar_ready_o=0` one cycle in IDLE; the same address then misses.
- Upstream backpressure:
  - Hold `r_ready_i=0` for 5 cycles → `r_valid_o`, `r_data_o` stable; `ar_ready_o` stays 0.
- Reset mid-burst:
  - Assert `rst_n` after beat 0 → `mem_r_ready_o`, `r_valid_o`, `ar_ready_o` = 0.
  - After release, the line misses.
